// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified memory port shared by instruction fetch (F) and
// data access (M). One requester owns the port for LAT wait cycles, then a
// single DONE cycle pulses the matching done flag before returning to IDLE.
// Ties are broken round-robin; data wins the first tie after reset.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          idone,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          ddone,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  typedef enum logic [1:0] {StIdle, StIAcc, StDAcc, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(LAT - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          last_d_q;  // last grant went to data
  logic          gsel_q;    // 1 = current grant is data
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] irdata_q;
  logic [DW-1:0] drdata_q;
  logic          idone_q;
  logic          ddone_q;
  logic          grant_d;

  // Data wins unless fetch also requests and data had the previous grant.
  assign grant_d = dreq & (~ireq | ~last_d_q);

  // Arbitration FSM with registered memory-port and done outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      last_d_q    <= 1'b0;
      gsel_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      idone_q     <= 1'b0;
      ddone_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q     <= StDAcc;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dwe;
            mem_addr_q  <= daddr;
            mem_wdata_q <= dwdata;
            cnt_q       <= 4'd0;
            last_d_q    <= 1'b1;
            gsel_q      <= 1'b1;
          end else if (ireq) begin
            state_q     <= StIAcc;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= iaddr;
            cnt_q       <= 4'd0;
            last_d_q    <= 1'b0;
            gsel_q      <= 1'b0;
          end
        end
        StIAcc, StDAcc: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            state_q  <= StDone;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (gsel_q) begin
              ddone_q <= 1'b1;
              // Stores leave the load-data register untouched.
              if (!mem_we_q) drdata_q <= mem_rdata;
            end else begin
              idone_q  <= 1'b1;
              irdata_q <= mem_rdata;
            end
          end
        end
        StDone: begin
          // Always pass through IDLE so the finishing requester can drop.
          state_q <= StIdle;
          idone_q <= 1'b0;
          ddone_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign idone     = idone_q;
  assign ddone     = ddone_q;
  assign stall_if  = ireq & ~idone_q;
  assign stall_mem = dreq & ~ddone_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LAT=2. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        idone;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        ddone;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(2), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ireq      (ireq),
    .iaddr     (iaddr),
    .irdata    (irdata),
    .idone     (idone),
    .dreq      (dreq),
    .dwe       (dwe),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .drdata    (drdata),
    .ddone     (ddone),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  task automatic test_reset();
    rst = 1'b0; ireq = 1'b1; dreq = 1'b1; dwe = 1'b0;
    iaddr = 32'h40; daddr = 32'h100; dwdata = 32'h0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %h want 0", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %h want 0", mem_we); end
    n_cmp++; if (idone !== 1'b0 || ddone !== 1'b0) begin
      n_err++; $display("FAIL rst_done: got %b%b want 00", idone, ddone); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_err++; $display("FAIL rst_mem: got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_cmp++; if (irdata !== 32'h0 || drdata !== 32'h0) begin
      n_err++; $display("FAIL rst_rdata: got %h/%h want 0/0", irdata, drdata); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_addr !== 32'h100) begin
      n_err++; $display("FAIL rst_first_tie: got %h want %h", mem_addr, 32'h100); end
    n_cmp++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL rst_grant_en: got %h want 1", mem_en); end
    ireq = 1'b0; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ddone !== 1'b1) begin n_err++; $display("FAIL rst_ddone: got %h want 1", ddone); end
    n_cmp++; if (drdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL rst_load: got %h want %h", drdata, 32'h1234_5678); end
    dreq = 1'b0;
    @(negedge clk);
    n_cmp++; if (ddone !== 1'b0) begin n_err++; $display("FAIL rst_ddone_end: got %h want 0", ddone); end
  endtask

  task automatic test_fetch();
    ireq = 1'b1; iaddr = 32'h0000_0040; mem_rdata = 32'h2108_0001;
    #1;
    n_cmp++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall0: got %h want 1", stall_if); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
        n_err++; $display("FAIL fetch_en%0d: got en=%h we=%h want en=1 we=0", c, mem_en, mem_we); end
      n_cmp++; if (mem_addr !== 32'h40) begin
        n_err++; $display("FAIL fetch_addr%0d: got %h want %h", c, mem_addr, 32'h40); end
      n_cmp++; if (idone !== 1'b0 || stall_if !== 1'b1) begin
        n_err++; $display("FAIL fetch_wait%0d: got idone=%h stall_if=%h want 0/1", c, idone, stall_if); end
    end
    @(negedge clk);
    n_cmp++; if (idone !== 1'b1) begin n_err++; $display("FAIL fetch_idone: got %h want 1", idone); end
    n_cmp++; if (irdata !== 32'h2108_0001) begin
      n_err++; $display("FAIL fetch_irdata: got %h want %h", irdata, 32'h2108_0001); end
    n_cmp++; if (mem_en !== 1'b0 || stall_if !== 1'b0) begin
      n_err++; $display("FAIL fetch_done_port: got en=%h stall_if=%h want 0/0", mem_en, stall_if); end
    ireq = 1'b0;
    @(negedge clk);
    n_cmp++; if (idone !== 1'b0 || mem_en !== 1'b0) begin
      n_err++; $display("FAIL fetch_pulse_end: got idone=%h en=%h want 0/0", idone, mem_en); end
  endtask

  task automatic test_store();
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'hDEAD_BEEF; mem_rdata = 32'hFFFF_0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
        n_err++; $display("FAIL store_we%0d: got en=%h we=%h want 1/1", c, mem_en, mem_we); end
      n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h100) begin
        n_err++; $display("FAIL store_data%0d: got %h@%h want deadbeef@100", c, mem_wdata, mem_addr); end
    end
    @(negedge clk);
    n_cmp++; if (ddone !== 1'b1 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL store_ddone: got ddone=%h we=%h want 1/0", ddone, mem_we); end
    n_cmp++; if (drdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL store_drdata_kept: got %h want %h", drdata, 32'h1234_5678); end
    dreq = 1'b0; dwe = 1'b0;
    @(negedge clk);
    n_cmp++; if (ddone !== 1'b0) begin n_err++; $display("FAIL store_pulse_end: got %h want 0", ddone); end
  endtask

  task automatic test_contention();
    // Fresh reset so the first tie goes to data again.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; iaddr = 32'h40; daddr = 32'h100;
    mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 16; k++) begin
      int  ph;
      bit  isd;
      bit  exp_en;
      bit  exp_id;
      bit  exp_dd;
      logic [31:0] exp_addr;
      ph = k % 4;
      isd = ((k / 4) % 2) == 0;
      exp_en = ph < 2;
      exp_dd = (ph == 2) && isd;
      exp_id = (ph == 2) && !isd;
      exp_addr = isd ? 32'h100 : 32'h40;
      @(negedge clk);
      n_cmp++; if (mem_en !== exp_en) begin
        n_err++; $display("FAIL cont_en_k%0d: got %h want %h", k, mem_en, exp_en); end
      n_cmp++; if (idone !== exp_id || ddone !== exp_dd) begin
        n_err++; $display("FAIL cont_done_k%0d: got i=%h d=%h want i=%h d=%h",
                          k, idone, ddone, exp_id, exp_dd); end
      if (exp_en) begin
        n_cmp++; if (mem_addr !== exp_addr) begin
          n_err++; $display("FAIL cont_order_k%0d: got %h want %h", k, mem_addr, exp_addr); end
      end
    end
    ireq = 1'b0; dreq = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL cont_idle: got %h want 0", mem_en); end
    n_cmp++; if (irdata !== 32'h5555_AAAA || drdata !== 32'h5555_AAAA) begin
      n_err++; $display("FAIL cont_rdata: got %h/%h want 5555aaaa", irdata, drdata); end
  endtask

  task automatic test_withdrawal();
    ireq = 1'b1; iaddr = 32'h40; mem_rdata = 32'h0BAD_0040;
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
      n_err++; $display("FAIL wd_grant: got en=%h addr=%h want 1/40", mem_en, mem_addr); end
    ireq = 1'b0; iaddr = 32'h80;
    #1;
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL wd_stall0: got %h want 0", stall_if); end
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
      n_err++; $display("FAIL wd_addr_hold: got en=%h addr=%h want 1/40", mem_en, mem_addr); end
    n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL wd_stall1: got %h want 0", stall_if); end
    @(negedge clk);
    n_cmp++; if (idone !== 1'b1) begin n_err++; $display("FAIL wd_idone: got %h want 1", idone); end
    n_cmp++; if (irdata !== 32'h0BAD_0040) begin
      n_err++; $display("FAIL wd_irdata: got %h want %h", irdata, 32'h0BAD_0040); end
    @(negedge clk);
    n_cmp++; if (idone !== 1'b0 || mem_en !== 1'b0) begin
      n_err++; $display("FAIL wd_no_regrant: got idone=%h en=%h want 0/0", idone, mem_en); end
  endtask

  task automatic test_mid_reset();
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h200; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL mr_cycle1: got %h want 1", mem_en); end
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL mr_cycle2: got %h want 1", mem_en); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0 || ddone !== 1'b0) begin
      n_err++; $display("FAIL mr_abort: got en=%h ddone=%h want 0/0", mem_en, ddone); end
    n_cmp++; if (drdata !== 32'h0 || mem_addr !== 32'h0) begin
      n_err++; $display("FAIL mr_clear: got drdata=%h addr=%h want 0/0", drdata, mem_addr); end
    rst = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 32'h200 || ddone !== 1'b0) begin
      n_err++; $display("FAIL mr_regrant: got en=%h addr=%h ddone=%h want 1/200/0",
                        mem_en, mem_addr, ddone); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ddone !== 1'b1 || drdata !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL mr_complete: got ddone=%h drdata=%h want 1/cafef00d", ddone, drdata); end
    dreq = 1'b0;
    @(negedge clk);
    n_cmp++; if (ddone !== 1'b0) begin n_err++; $display("FAIL mr_pulse_end: got %h want 0", ddone); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_withdrawal();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single unified memory port shared by the 5-stage pipeline's instruction fetch (F) and data access (M).
- Grants one requester at a time and holds the port for a fixed number of wait cycles.
- Returns the read data to the granted requester.
- Generates stall requests that the hazard logic ORs into its existing stall and flush terms.
- Sits between the F/M stages and the external memory model.

Parameters:
- LAT, 2, memory wait cycles per access; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- ireq  in  1  fetch request; held by F until idone.
- iaddr  in  AW  fetch address (PC).
- irdata  out  DW  fetched instruction; valid when idone=1.
- idone  out  1  one-cycle pulse: fetch complete.
- dreq  in  1  data request; held by M (lw/sw) until ddone.
- dwe  in  1  1 = store, 0 = load.
- daddr  in  AW  data address.
- dwdata  in  DW  store data.
- drdata  out  DW  load data; valid when ddone=1.
- ddone  out  1  one-cycle pulse: data access complete.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; sampled on the last access cycle.
- stall_if  out  1  = ireq & ~idone (combinational).
- stall_mem  out  1  = dreq & ~ddone (combinational).

Behaviour:
- State encoding:
  - FSM states: IDLE, IACC, DACC, DONE.
  - cnt: 4-bit wait counter.
  - last_d: 1 = the last grant went to data.
  - gsel: latched grant identity (fetch or data), used by DONE.
- Reset (rst=0 at a clock edge), whether idle or mid-access:
  - State returns to IDLE; cnt=0; last_d=0.
  - mem_en, mem_we, idone and ddone are 0.
  - mem_addr, mem_wdata, irdata and drdata are 0.
  - Any in-flight access is discarded and no done pulse is issued.
- IDLE:
  - dreq only: grant data and go to DACC.
  - ireq only: grant fetch and go to IACC.
  - Both requesting: round-robin. Grant fetch if last_d=1, otherwise data. After reset, data wins the first tie.
  - On a grant: latch address, write data and dwe into the mem_* registers; cnt=0; record the grant in last_d and gsel.
  - No request: stay in IDLE with mem_en=0.
- IACC / DACC:
  - mem_en=1 for exactly LAT cycles; mem_we = latched dwe in DACC, 0 in IACC.
  - Address and data stay stable throughout, even if the requester's inputs change.
  - cnt increments each cycle.
  - When cnt==LAT-1, at the next edge: mem_rdata is captured into irdata (IACC) or into drdata (DACC load only; stores leave drdata unchanged). State moves to DONE.
- DONE:
  - Exactly one cycle; idone or ddone = 1 according to gsel.
  - mem_en=0, mem_we=0.
  - Next state is unconditionally IDLE. No re-grant while the completing requester's request is still visible.
- Latency:
  - Request seen in IDLE at edge t: done is high in cycle t+LAT+1.
  - Port occupancy per access is LAT+2 cycles.
- Request withdrawn mid-access (e.g. flush of F): the access completes and the done pulse still fires; the stall output is already 0 because req=0.
- Priority changes only at grant time; a request arriving during an access waits in IDLE arbitration.
- Starvation: none. With both requests held continuously, grants strictly alternate.
- irdata and drdata hold their value until the next capture.

Test Plan:
- Reset: rst=0 for 2 cycles with ireq=dreq=1 -> all outputs 0, state IDLE; after release, the first tie grants data (mem_addr=daddr).
- Fetch alone, LAT=2: ireq=1, iaddr=0x0000_0040, mem_rdata=0x2108_0001 during IACC -> mem_en high 2 cycles; idone pulses 3 cycles after the IDLE sample; irdata=0x2108_0001; stall_if high until idone.
- Store: dreq=1, dwe=1, daddr=0x100, dwdata=0xDEAD_BEEF -> mem_we=1 and mem_wdata=0xDEAD_BEEF for 2 cycles; ddone pulses; drdata unchanged.
- Contention: ireq and dreq held continuously for 4 accesses -> grant order D, I, D, I; each done pulse lasts exactly 1 cycle; no back-to-back re-grant to the same requester.
- Withdrawal: during IACC, drop ireq and change iaddr to 0x80 -> mem_addr stays 0x40; idone still pulses; stall_if=0 throughout.
- Mid-access reset: rst=0 on the second DACC cycle -> next cycle mem_en=0, no ddone pulse, state IDLE; a subsequent request completes normally.
